// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback collector.
// Source indices, data widths and the buffered entry layout.
package wb_pkg;

  localparam int WB_NR_SRC        = 5;
  localparam int WB_XLEN          = 32;
  localparam int WB_TRANS_ID_BITS = 4;

  localparam int WB_SRC_FLU   = 0;
  localparam int WB_SRC_LOAD  = 1;
  localparam int WB_SRC_STORE = 2;
  localparam int WB_SRC_FPU   = 3;
  localparam int WB_SRC_X     = 4;

  typedef struct packed {
    logic [WB_TRANS_ID_BITS-1:0] trans_id;
    logic [WB_XLEN-1:0]          result;
    logic                        ex_valid;
    logic [WB_XLEN-1:0]          ex_cause;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO: wrapping read/write pointers plus an
// occupancy count, synchronous flush, asynchronous active-high reset.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T             mem_q [DEPTH];
  T             mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_collector.sv
// Buffers execute-stage results per source and drains them round-robin
// onto the scoreboard write ports. Optional WB_COLLECTOR_BYPASS_EN.
module wb_collector
  import wb_pkg::*;
#(
  parameter int NR_SRC        = WB_NR_SRC,
  parameter int NR_WB_PORTS   = 2,
  parameter int DEPTH         = 2,
  parameter int TRANS_ID_BITS = WB_TRANS_ID_BITS,
  parameter int XLEN          = WB_XLEN
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic [NR_SRC-1:0]                         src_valid_i,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_result_i,
  input  logic [NR_SRC-1:0]                         src_ex_valid_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]               src_ex_cause_i,
  output logic [NR_SRC-1:0]                         src_ready_o,
  output logic [NR_WB_PORTS-1:0]                    wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_o,
  output logic [NR_WB_PORTS-1:0]                    wb_ex_valid_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_ex_cause_o,
  output logic                                      overflow_o
);

  localparam int SW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  wb_entry_t         in_ent [NR_SRC];
  wb_entry_t         head   [NR_SRC];
  logic [NR_SRC-1:0] full, empty, push, pop, req, byp, used;

  logic [NR_WB_PORTS-1:0] gnt_vld;
  logic [SW-1:0]          gnt_src [NR_WB_PORTS];

  logic [SW-1:0] rr_q, rr_d;
  logic          overflow_q, overflow_d;

  assign src_ready_o = ~full;
  assign overflow_o  = overflow_q;

  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    assign in_ent[i] = '{
      trans_id: src_trans_id_i[i],
      result:   src_result_i[i],
      ex_valid: src_ex_valid_i[i],
      ex_cause: src_ex_cause_i[i]
    };

    wb_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_entry_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .data_i  (in_ent[i]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // An empty FIFO with a valid input may compete directly when bypassing.
  always_comb begin
    byp = '0;
`ifdef WB_COLLECTOR_BYPASS_EN
    byp = empty & src_valid_i & {NR_SRC{~flush_i}};
`endif
    req = ~empty | byp;
  end

  // Scanning from rr_q, the first NR_WB_PORTS requesters fill ports in order.
  always_comb begin
    int n;
    int idx;
    gnt_vld = '0;
    gnt_src = '{default: '0};
    n       = 0;
    idx     = 0;
    for (int k = 0; k < NR_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NR_SRC) idx = idx - NR_SRC;
      if (req[idx] && n < NR_WB_PORTS) begin
        gnt_vld[n] = 1'b1;
        gnt_src[n] = SW'(idx);
        n          = n + 1;
      end
    end
  end

  always_comb begin
    wb_entry_t     ent;
    logic [SW-1:0] s;
    ent           = '0;
    s             = '0;
    pop           = '0;
    used          = '0;
    rr_d          = rr_q;
    wb_valid_o    = '0;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_valid_o = '0;
    wb_ex_cause_o = '0;
    if (flush_i) begin
      rr_d = '0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (gnt_vld[p]) begin
          s = gnt_src[p];
          if (byp[s]) begin
            ent     = in_ent[s];
            used[s] = 1'b1;
          end else begin
            ent    = head[s];
            pop[s] = 1'b1;
          end
          wb_valid_o[p]    = 1'b1;
          wb_trans_id_o[p] = ent.trans_id;
          wb_result_o[p]   = ent.result;
          wb_ex_valid_o[p] = ent.ex_valid;
          wb_ex_cause_o[p] = ent.ex_cause;
          rr_d = (s == SW'(NR_SRC - 1)) ? '0 : s + 1'b1;
        end
      end
    end
  end

  // Readiness comes from registered state; a same-cycle pop never frees a slot.
  assign push = src_valid_i & ~full & {NR_SRC{~flush_i}} & ~used;

  assign overflow_d = |(src_valid_i & full) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_wb_collector.sv
// Directed self-checking bench for wb_collector (default build).
// Expected values are hand-computed from the arbitration rules.
module tb_wb_collector;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic [4:0]       src_valid_i;
  logic [4:0][3:0]  src_trans_id_i;
  logic [4:0][31:0] src_result_i;
  logic [4:0]       src_ex_valid_i;
  logic [4:0][31:0] src_ex_cause_i;
  logic [4:0]       src_ready_o;
  logic [1:0]       wb_valid_o;
  logic [1:0][3:0]  wb_trans_id_o;
  logic [1:0][31:0] wb_result_o;
  logic [1:0]       wb_ex_valid_o;
  logic [1:0][31:0] wb_ex_cause_o;
  logic             overflow_o;

  int errors = 0;
  int checks = 0;

  wb_collector dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .src_valid_i    (src_valid_i),
    .src_trans_id_i (src_trans_id_i),
    .src_result_i   (src_result_i),
    .src_ex_valid_i (src_ex_valid_i),
    .src_ex_cause_i (src_ex_cause_i),
    .src_ready_o    (src_ready_o),
    .wb_valid_o     (wb_valid_o),
    .wb_trans_id_o  (wb_trans_id_o),
    .wb_result_o    (wb_result_o),
    .wb_ex_valid_o  (wb_ex_valid_o),
    .wb_ex_cause_o  (wb_ex_cause_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    src_valid_i    = '0;
    src_trans_id_i = '0;
    src_result_i   = '0;
    src_ex_valid_i = '0;
    src_ex_cause_i = '0;
  endtask

  task automatic put(input int s, input logic [3:0] id,
                     input logic [31:0] res);
    src_valid_i[s]    = 1'b1;
    src_trans_id_i[s] = id;
    src_result_i[s]   = res;
  endtask

  initial begin
    clr();
    #2;
    chk("rst_valid", 64'(wb_valid_o), 64'h0);
    chk("rst_ready", 64'(src_ready_o), 64'h1f);
    chk("rst_ovf", 64'(overflow_o), 64'h0);
    chk("rst_res", wb_result_o, 64'h0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    // single load result
    put(1, 4'd3, 32'hDEAD);
    #1;
    chk("t1_no_comb", 64'(wb_valid_o), 64'h0);
    tick();
    clr();
    chk("t1_valid", 64'(wb_valid_o), 64'h1);
    chk("t1_id", 64'(wb_trans_id_o[0]), 64'h3);
    chk("t1_res", 64'(wb_result_o[0]), 64'hDEAD);
    chk("t1_p1_res", 64'(wb_result_o[1]), 64'h0);
    tick();
    chk("t1_idle", 64'(wb_valid_o), 64'h0);

    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // five simultaneous sources from rr=0
    for (int s = 0; s < 5; s++) put(s, 4'(s), 32'h100 + 32'(s));
    tick();
    clr();
    chk("t2_c1_valid", 64'(wb_valid_o), 64'h3);
    chk("t2_c1_id0", 64'(wb_trans_id_o[0]), 64'h0);
    chk("t2_c1_id1", 64'(wb_trans_id_o[1]), 64'h1);
    tick();
    chk("t2_c2_id0", 64'(wb_trans_id_o[0]), 64'h2);
    chk("t2_c2_id1", 64'(wb_trans_id_o[1]), 64'h3);
    tick();
    chk("t2_c3_valid", 64'(wb_valid_o), 64'h1);
    chk("t2_c3_id0", 64'(wb_trans_id_o[0]), 64'h4);
    chk("t2_c3_p1res", 64'(wb_result_o[1]), 64'h0);
    tick();
    chk("t2_idle", 64'(wb_valid_o), 64'h0);
    // rr back at 0: source 0 must beat source 4 for port 0
    put(0, 4'd5, 32'h55);
    put(4, 4'd6, 32'h66);
    tick();
    clr();
    chk("t2_rr_id0", 64'(wb_trans_id_o[0]), 64'h5);
    chk("t2_rr_id1", 64'(wb_trans_id_o[1]), 64'h6);
    tick();

    // FPU back-to-back, alone
    put(3, 4'd1, 32'hA1);
    tick();
    chk("t3_a1_res", 64'(wb_result_o[0]), 64'hA1);
    chk("t3_a1_rdy", 64'(src_ready_o), 64'h1f);
    put(3, 4'd2, 32'hA2);
    tick();
    clr();
    chk("t3_a2_res", 64'(wb_result_o[0]), 64'hA2);
    chk("t3_a2_rdy", 64'(src_ready_o[3]), 64'h1);
    chk("t3_a2_ovf", 64'(overflow_o), 64'h0);
    tick();
    chk("t3_idle", 64'(wb_valid_o), 64'h0);
    chk("t3_ovf", 64'(overflow_o), 64'h0);

    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // stress: sources 0,1,3 for three cycles; FPU overflows on its third
    for (int s = 0; s < 4; s++)
      if (s != 2) put(s, 4'(s * 4), 32'h100 * 32'(s));
    tick();
    chk("st_e1_valid", 64'(wb_valid_o), 64'h3);
    chk("st_e1_res0", 64'(wb_result_o[0]), 64'h000);
    chk("st_e1_res1", 64'(wb_result_o[1]), 64'h100);
    chk("st_e1_rdy", 64'(src_ready_o), 64'h1f);
    for (int s = 0; s < 4; s++)
      if (s != 2) put(s, 4'(s * 4 + 1), 32'h100 * 32'(s) + 32'h1);
    src_ex_valid_i[3] = 1'b1;
    src_ex_cause_i[3] = 32'h7;
    tick();
    chk("st_e2_res0", 64'(wb_result_o[0]), 64'h300);
    chk("st_e2_res1", 64'(wb_result_o[1]), 64'h001);
    chk("st_e2_rdy", 64'(src_ready_o), 64'h17);
    clr();
    for (int s = 0; s < 4; s++)
      if (s != 2) put(s, 4'(s * 4 + 2), 32'h100 * 32'(s) + 32'h2);
    tick();
    clr();
    chk("st_e3_ovf", 64'(overflow_o), 64'h1);
    chk("st_e3_rdy", 64'(src_ready_o), 64'h1d);
    chk("st_e3_res0", 64'(wb_result_o[0]), 64'h101);
    chk("st_e3_res1", 64'(wb_result_o[1]), 64'h301);
    chk("st_e3_exv", 64'(wb_ex_valid_o), 64'h2);
    chk("st_e3_cause", 64'(wb_ex_cause_o[1]), 64'h7);
    tick();
    chk("st_e4_ovf", 64'(overflow_o), 64'h0);
    chk("st_e4_rdy", 64'(src_ready_o), 64'h1f);
    chk("st_e4_res0", 64'(wb_result_o[0]), 64'h002);
    chk("st_e4_res1", 64'(wb_result_o[1]), 64'h102);
    tick();
    chk("st_e5_idle", 64'(wb_valid_o), 64'h0);

    // flush with three sources buffered, plus a push in the flush cycle
    for (int s = 0; s < 3; s++) put(s, 4'(s), 32'h200 + 32'(s));
    tick();
    clr();
    chk("fl_pre_valid", 64'(wb_valid_o), 64'h3);
    flush_i = 1'b1;
    put(4, 4'd9, 32'h999);
    #1;
    chk("fl_now_valid", 64'(wb_valid_o), 64'h0);
    tick();
    flush_i = 1'b0;
    clr();
    chk("fl_next_valid", 64'(wb_valid_o), 64'h0);
    chk("fl_next_rdy", 64'(src_ready_o), 64'h1f);
    tick();
    chk("fl_after_valid", 64'(wb_valid_o), 64'h0);

    // reset in the middle of a drain
    for (int s = 0; s < 5; s++) put(s, 4'(s), 32'h300 + 32'(s));
    tick();
    clr();
    chk("rs_pre_valid", 64'(wb_valid_o), 64'h3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rs_valid", 64'(wb_valid_o), 64'h0);
    chk("rs_res", wb_result_o, 64'h0);
    chk("rs_rdy", 64'(src_ready_o), 64'h1f);
    chk("rs_ovf", 64'(overflow_o), 64'h0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();
    chk("rs_after_valid", 64'(wb_valid_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
